uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_receiver.sv | 175 +++++++++++++++++
 tb/tb_uart_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, oversampling and mid-bit tick constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVS = 16;

  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_MID  = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Oversampling divider, floored, never below one clock per tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int div;
    div = clk_hz / (baud * ovs);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: a reloading down-counter that ticks on terminal count.
// restart realigns the phase so the first tick lands on the very next clock.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (restart)
      cnt_d = '0;
    else if (cnt_q == '0)
      cnt_d = RELOAD;
    else
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// 8-bit UART receiver with 16x oversampling, 3-sample majority vote and a valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge on rxs
// START     | qualifying the start bit (glitch rejection at tick 7)
// DATA      | shifting in 8 data bits, LSB first
// PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | checking the stop bit, delivering the byte at tick 9
// WAIT_HIGH | framing error seen, waiting for one full bit time of idle line
module uart_receiver #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 9600,
  parameter int OVS    = uart_pkg::OVS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);

  rx_state_t  state_q;
  logic       sync1_q, rxs_q, rxs_prev_q;
  logic [3:0] tick_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, rx_data_q;
  logic [1:0] samp_q;
  logic       rx_valid_q, frame_err_q, overrun_q, busy_q;
`ifdef UART_RX_PARITY_EN
  logic       par_err_q;
`endif

  logic tick, restart, fall, vote, mid_tick, last_tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign fall      = rxs_prev_q & ~rxs_q;
  assign restart   = (state_q == IDLE) & fall;
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign mid_tick  = tick & (tick_cnt_q == TICK_MID);
  assign last_tick = tick & (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync1_q     <= RxD;
      rxs_q       <= sync1_q;
      rxs_prev_q  <= rxs_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_valid_q && rx_ready)
        rx_valid_q <= 1'b0;
      if (tick)
        tick_cnt_q <= tick_cnt_q + 4'd1;
      if (tick && tick_cnt_q == TICK_S0)
        samp_q[0] <= rxs_q;
      if (tick && tick_cnt_q == TICK_S1)
        samp_q[1] <= rxs_q;

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick && tick_cnt_q == TICK_S0 && rxs_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_tick) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (mid_tick)
            shift_q <= {vote, shift_q[7:1]};
          if (last_tick) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7)
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (mid_tick)
            par_err_q <= vote ^ (^shift_q);
          if (last_tick)
            state_q <= STOP;
        end
`endif
        STOP: begin
          if (mid_tick) begin
            if (!vote) begin
              frame_err_q <= 1'b1;
              tick_cnt_q  <= '0;
              state_q     <= WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
            end else if (par_err_q) begin
              frame_err_q <= 1'b1;
              state_q     <= IDLE;
              busy_q      <= 1'b0;
`endif
            end else begin
              // A handshake in this same cycle frees the slot, so the new byte wins.
              if (rx_valid_q && !rx_ready) begin
                overrun_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        WAIT_HIGH: begin
          // Any low sample restarts the one-bit idle qualification (break handling).
          if (!rxs_q) begin
            tick_cnt_q <= '0;
          end else if (last_tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: vector table of single frames plus hand-written corner sequences.
module tb_uart_receiver;

  // 1228800 / (9600 * 16) = 8 clocks per tick, 128 clocks per bit.
  localparam int CLK_HZ = 1228800;
  localparam int BAUD   = 9600;
  localparam int DIV    = 8;
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  // Clocks from the RxD falling edge to rx_valid seen high: 2 sync flops, edge detect,
  // one clock to the first tick, then stop-bit tick 9 is tick number (NBITS-1)*16+9.
  localparam int LAT    = 4 + ((NBITS - 1) * 16 + 9) * DIV;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_rises;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int  n_vec = 0;
  int  n_bad = 0;
  int  rises = 0, ferrs = 0, ovrs = 0, vcycles = 0;
  time t_rise = 0;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  uart_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
      rises++;
      t_rise = $time;
    end
    if (rx_valid === 1'b1) vcycles++;
    if (frame_err === 1'b1) ferrs++;
    if (overrun === 1'b1) ovrs++;
    valid_prev = rx_valid;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int nbits);
    RxD = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  // Called at a negedge; leaves the line high at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RxD = (^d) ^ par_flip;
    repeat (BIT) @(negedge clk);
`else
    if (par_flip) RxD = 1'b1;
`endif
    RxD = stop_v;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
  endtask

  initial begin
    vec_t vecs [6];
    int   r0, f0, o0, c0;
    time  t0;

    vecs[0] = '{data: 8'hA5, stop_v: 1'b1, exp_rises: 1, exp_data: 8'hA5, exp_ferr: 0};
    vecs[1] = '{data: 8'h3C, stop_v: 1'b1, exp_rises: 1, exp_data: 8'h3C, exp_ferr: 0};
    vecs[2] = '{data: 8'h00, stop_v: 1'b1, exp_rises: 1, exp_data: 8'h00, exp_ferr: 0};
    vecs[3] = '{data: 8'hFF, stop_v: 1'b1, exp_rises: 1, exp_data: 8'hFF, exp_ferr: 0};
    vecs[4] = '{data: 8'h55, stop_v: 1'b0, exp_rises: 0, exp_data: 8'hFF, exp_ferr: 1};
    vecs[5] = '{data: 8'h81, stop_v: 1'b1, exp_rises: 1, exp_data: 8'h81, exp_ferr: 0};

    reset    = 1'b0;
    RxD      = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_data",   32'(rx_data),   32'h00);
    check("reset rx_valid",  32'(rx_valid),  32'h0);
    check("reset busy",      32'(busy),      32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun",   32'(overrun),   32'h0);
    reset = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) begin
      r0 = rises; f0 = ferrs; o0 = ovrs; c0 = vcycles; t0 = $time;
      send_frame(vecs[i].data, vecs[i].stop_v, 1'b0);
      idle(2);
      check($sformatf("v%0d rises", i),         32'(rises - r0),   32'(vecs[i].exp_rises));
      check($sformatf("v%0d valid_cycles", i),  32'(vcycles - c0), 32'(vecs[i].exp_rises));
      check($sformatf("v%0d rx_data", i),       32'(rx_data),      32'(vecs[i].exp_data));
      check($sformatf("v%0d frame_err", i),     32'(ferrs - f0),   32'(vecs[i].exp_ferr));
      check($sformatf("v%0d overrun", i),       32'(ovrs - o0),    32'h0);
      check($sformatf("v%0d busy", i),          32'(busy),         32'h0);
      if (i == 0)
        check("a5 latency clocks", 32'((t_rise - t0) / 10), 32'(LAT));
    end

    // 5-tick glitch on the idle line is rejected.
    r0 = rises;
    RxD = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    RxD = 1'b1;
    check("glitch busy during", 32'(busy), 32'h1);
    idle(1);
    check("glitch busy after", 32'(busy), 32'h0);
    check("glitch rises", 32'(rises - r0), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2);
    check("post-glitch rises", 32'(rises - r0), 32'h1);
    check("post-glitch data",  32'(rx_data),    32'h3C);

    // Bad stop bit followed by a 2-bit break, then a clean byte.
    r0 = rises; f0 = ferrs;
    send_frame(8'h55, 1'b0, 1'b0);
    RxD = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    idle(2);
    check("break frame_err", 32'(ferrs - f0), 32'h1);
    check("break rises",     32'(rises - r0), 32'h0);
    check("break busy",      32'(busy),       32'h0);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2);
    check("after-break rises", 32'(rises - r0), 32'h1);
    check("after-break data",  32'(rx_data),    32'h12);
    check("after-break ferr",  32'(ferrs - f0), 32'h1);

    // Overrun: second byte arrives while the first is still unconsumed.
    rx_ready = 1'b0;
    r0 = rises; o0 = ovrs;
    send_frame(8'h01, 1'b1, 1'b0);
    idle(1);
    send_frame(8'h02, 1'b1, 1'b0);
    idle(2);
    check("overrun pulses",   32'(ovrs - o0),  32'h1);
    check("overrun rises",    32'(rises - r0), 32'h1);
    check("overrun rx_data",  32'(rx_data),    32'h01);
    check("overrun rx_valid", 32'(rx_valid),   32'h1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("overrun drained", 32'(rx_valid), 32'h0);

    // Handshake in the very cycle the next byte completes.
    rx_ready = 1'b0;
    o0 = ovrs;
    send_frame(8'h6B, 1'b1, 1'b0);
    idle(1);
    fork
      send_frame(8'hC4, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(2);
    check("same-cycle rx_data",  32'(rx_data),   32'hC4);
    check("same-cycle rx_valid", 32'(rx_valid),  32'h1);
    check("same-cycle overrun",  32'(ovrs - o0), 32'h0);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("same-cycle drained", 32'(rx_valid), 32'h0);

    // Reset in the middle of data bit 4 of 0xFF.
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'h1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-reset rx_data",   32'(rx_data),   32'h00);
    check("mid-reset rx_valid",  32'(rx_valid),  32'h0);
    check("mid-reset busy",      32'(busy),      32'h0);
    check("mid-reset frame_err", 32'(frame_err), 32'h0);
    check("mid-reset overrun",   32'(overrun),   32'h0);
    reset = 1'b1;
    r0 = rises; f0 = ferrs; o0 = ovrs;
    repeat (5 * BIT) @(negedge clk);
    idle(1);
    check("aborted frame busy",  32'(busy),       32'h0);
    check("aborted frame rises", 32'(rises - r0), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2);
    check("post-reset rises", 32'(rises - r0), 32'h1);
    check("post-reset data",  32'(rx_data),    32'h81);
    check("post-reset ferr",  32'(ferrs - f0), 32'h0);
    check("post-reset ovr",   32'(ovrs - o0),  32'h0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so the even-parity bit must be 1.
    r0 = rises; f0 = ferrs;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    check("bad parity frame_err", 32'(ferrs - f0), 32'h1);
    check("bad parity rises",     32'(rises - r0), 32'h0);
    check("bad parity rx_data",   32'(rx_data),    32'h81);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2);
    check("good parity rises", 32'(rises - r0), 32'h1);
    check("good parity data",  32'(rx_data),    32'h07);
    check("good parity ferr",  32'(ferrs - f0), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
